parameter_bank: RTL
===================

Name: parameter_bank

Overview:
- Generalised MIDI control-change decoder that maps up to NUM_PARAMS controller numbers onto a bank of parameter registers VALUE_W bits wide.
- Supports a per-channel filter and 14-bit MSB/LSB controller pairing.
- Queues every parameter update as an indexed change event in a small FIFO with a valid/ready handshake.
- Sits between the MIDI message decoder and the synth-voice and envelope consumers; successor to the fixed single-change parameter control block.

Parameters:
- NUM_PARAMS, 8, number of parameter slots (1..32).
- VALUE_W, 7, stored value width (7..14); above 7 enables MSB/LSB pairing.
- OMNI, 1, 1 = accept all channels; 0 = accept only LISTEN_CHANNEL.
- LISTEN_CHANNEL, 0, 4-bit MIDI channel accepted when OMNI=0.
- FIFO_DEPTH, 4, change-event queue depth (power of 2, >=2).
- CC_MAP, PARAMETER::DEFAULT_CC_MAP, per-slot 7-bit MSB controller number (slot i at bits [7i+6:7i]).
- DEFAULTS, PARAMETER::DEFAULT_VALUES, per-slot reset value, VALUE_W bits each.

Ports:
- clock_50_000_000  in  1  system clock
- reset_l  in  1  asynchronous, active-low reset
- message  in  MIDI::message_t  decoded MIDI message (message_type, channel, data_byte1, data_byte2)
- message_ready  in  1  one-cycle strobe: message is valid
- values  out  NUM_PARAMS*VALUE_W  parameter registers, slot i at [VALUE_W*i +: VALUE_W]
- change_valid  out  1  change-event FIFO non-empty
- change_index  out  $clog2(NUM_PARAMS) (min 1)  slot index at FIFO head
- change_ready  in  1  consumer pops the head when change_valid && change_ready
- overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (asynchronous, reset_l low): values = DEFAULTS; FIFO empty; change_valid=0; change_index=0; overflow=0. Reset mid-operation discards all queued events.
- Accept condition: message_ready && message_type==CONTROL_CHANGE && (OMNI || channel==LISTEN_CHANNEL). All other messages leave all state unchanged.
- Slot match:
  - MSB match: data_byte1 == CC_MAP[i].
  - LSB match: VALUE_W>7, CC_MAP[i]<32, and data_byte1 == CC_MAP[i]+32.
  - When several slots match, the lowest index wins. Exactly one slot is updated per message.
- MSB write: value[VALUE_W-1 -: 7] = data_byte2; all lower bits cleared to 0. This is the MIDI rule: a new MSB resets the LSB.
- LSB write: value[VALUE_W-8:0] = data_byte2[6 -: VALUE_W-7]. The top bits of the LSB byte are kept; the rest is truncated. Upper 7 bits are unchanged.
- Latency:
  - The values register updates on the clock edge where message_ready is sampled.
  - The event is pushed on that same edge, so change_valid is high in the next cycle at the earliest.
- Events are pushed even when the new value equals the old value.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the address.
  - Full = (pointer MSBs differ) and (address bits equal).
  - Push while full and no pop in the same cycle: event dropped, overflow set to 1. overflow stays set until reset.
  - Push and pop in the same cycle while full: both succeed.
  - Pop while empty: ignored.
  - change_index is registered head data and is valid only while change_valid=1.
- Handshake: change_valid stays asserted and change_index stays stable until popped; the consumer may hold change_ready high permanently.
- Pointer wrap: addresses wrap modulo FIFO_DEPTH; there is no special case at wrap.

Optional Feature:
- PARAMETER_BANK_RESET_ALL_EN
- Defined: an accepted CC 121 (Reset All Controllers) restores every slot to DEFAULTS in one cycle. It pushes one event with index NUM_PARAMS-1 plus a reserved flag bit (change_index is widened by 1 bit, MSB=1 meaning "all changed"). The overflow rule applies to this event as to any other.
- Undefined: CC 121 is treated like any other controller number and matches a slot only if CC_MAP contains it.

Decomposition:
- PARAMETER package:
  - DEFAULT_CC_MAP and DEFAULT_VALUES constants.
  - MAX_PARAMS=32 constant.
  - CC_RESET_ALL=7'd121 constant.
  - param_index_t typedef.
- MIDI package (existing): message_t and CONTROL_CHANGE.
- Sub-module change_fifo: generic synchronous FIFO (WIDTH, DEPTH) with push/pop/full/empty. It is instantiated once and is reusable by the arpeggiator.

Test Plan:
- Reset with DEFAULTS slot0=7'd64 -> values slot0==64, change_valid=0, overflow=0; no event after reset release.
- VALUE_W=7, CC_MAP slot2=7'd74; CC ch0 data1=74 data2=100 -> next cycle slot2==100, change_valid=1, change_index=2; pop -> change_valid=0.
- VALUE_W=14, slot1 CC 7: MSB 7/0x40 -> slot1==0x2000; then LSB 39/0x11 -> slot1==0x2011; then MSB 7/0x41 -> slot1==0x2080 (LSB cleared); three events queued.
- OMNI=0, LISTEN_CHANNEL=3: CC on channel 5 -> no change, no event; same CC on channel 3 -> update and event. Note-on on channel 3 -> ignored.
- FIFO_DEPTH=4, change_ready=0, 5 matching CCs -> 4 events queued, overflow=1, 5th value still written to values. Then 5th push concurrent with pop when full -> no drop.
- Reset asserted with 3 events queued -> change_valid falls immediately (asynchronously); values back to DEFAULTS.

Source files
------------

// File: rtl/midi_pkg.sv
// Decoded MIDI channel-message type shared by the message decoder and its consumers.
package MIDI;

  typedef enum logic [2:0] {
    NOTE_OFF         = 3'd0,
    NOTE_ON          = 3'd1,
    POLY_PRESSURE    = 3'd2,
    CONTROL_CHANGE   = 3'd3,
    PROGRAM_CHANGE   = 3'd4,
    CHANNEL_PRESSURE = 3'd5,
    PITCH_BEND       = 3'd6,
    SYSTEM           = 3'd7
  } message_type_t;

  typedef struct packed {
    message_type_t message_type;
    logic [3:0]    channel;
    logic [6:0]    data_byte1;
    logic [6:0]    data_byte2;
  } message_t;

endpackage

// File: rtl/parameter_bank_pkg.sv
// Constants for the parameter bank: default controller map, default values,
// and the Reset All Controllers number.
package PARAMETER;

  localparam int MAX_PARAMS  = 32;
  localparam int MAX_VALUE_W = 14;

  localparam logic [6:0] CC_RESET_ALL = 7'd121;

  typedef logic [$clog2(MAX_PARAMS)-1:0] param_index_t;

  // Slots 0..7: pan, volume, cutoff, resonance, attack, release, mod wheel, expression.
  // Unused slots park on CC 127, which no consumer assigns.
  localparam logic [MAX_PARAMS*7-1:0] DEFAULT_CC_MAP = {
    {24{7'h7F}},
    7'd11, 7'd1, 7'd72, 7'd73, 7'd71, 7'd74, 7'd7, 7'd10
  };

  // Packed with the default 7-bit stride: pan centred, volume 100, rest zero.
  localparam logic [MAX_PARAMS*MAX_VALUE_W-1:0] DEFAULT_VALUES = {
    {(MAX_PARAMS*MAX_VALUE_W-14){1'b0}}, 7'd100, 7'd64
  };

endpackage

// File: rtl/parameter_bank_change_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; also used by the arpeggiator.
module change_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_l,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/parameter_bank.sv
// MIDI control-change decoder into a bank of parameter registers with a change-event queue.
// Optional: PARAMETER_BANK_RESET_ALL_EN makes CC 121 restore every slot and queue an "all" event.
module parameter_bank
  import MIDI::*;
  import PARAMETER::*;
#(
  parameter int NUM_PARAMS = 8,
  parameter int VALUE_W = 7,
  parameter bit OMNI = 1'b1,
  parameter logic [3:0] LISTEN_CHANNEL = 4'd0,
  parameter int FIFO_DEPTH = 4,
  parameter logic [MAX_PARAMS*7-1:0] CC_MAP = DEFAULT_CC_MAP,
  parameter logic [MAX_PARAMS*MAX_VALUE_W-1:0] DEFAULTS = DEFAULT_VALUES,
  localparam int SLOT_W = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1,
`ifdef PARAMETER_BANK_RESET_ALL_EN
  localparam int IDX_W = SLOT_W + 1
`else
  localparam int IDX_W = SLOT_W
`endif
) (
  input  logic                          clock_50_000_000,
  input  logic                          reset_l,
  input  message_t                      message,
  input  logic                          message_ready,
  output logic [NUM_PARAMS*VALUE_W-1:0] values,
  output logic                          change_valid,
  output logic [IDX_W-1:0]              change_index,
  input  logic                          change_ready,
  output logic                          overflow
);

  localparam int LSB_W = VALUE_W - 7;
  localparam logic [VALUE_W-1:0] UPPER_MASK = VALUE_W'(7'h7F) << LSB_W;

  logic               accept;
  logic               hit, hit_lsb;
  param_index_t       hit_idx;
  logic               reset_all;
  logic [VALUE_W-1:0] msb_val, lsb_bits;
  logic               push, full, empty;
  logic [IDX_W-1:0]   push_data;
  logic [VALUE_W-1:0] slot_q [NUM_PARAMS];

  assign accept = message_ready && (message.message_type == CONTROL_CHANGE)
                  && (OMNI || (message.channel == LISTEN_CHANNEL));

  // Walk from the top slot down so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_lsb = 1'b0;
    hit_idx = '0;
    for (int i = NUM_PARAMS-1; i >= 0; i--) begin
      if (message.data_byte1 == CC_MAP[7*i +: 7]) begin
        hit     = 1'b1;
        hit_lsb = 1'b0;
        hit_idx = param_index_t'(i);
      end else if ((VALUE_W > 7) && (CC_MAP[7*i +: 7] < 7'd32)
                   && (message.data_byte1 == CC_MAP[7*i +: 7] + 7'd32)) begin
        hit     = 1'b1;
        hit_lsb = 1'b1;
        hit_idx = param_index_t'(i);
      end
    end
  end

  // A new MSB clears the fine bits; an LSB keeps only the top bits of its byte.
  assign msb_val  = VALUE_W'(message.data_byte2) << LSB_W;
  assign lsb_bits = VALUE_W'(message.data_byte2 >> (7 - LSB_W));

`ifdef PARAMETER_BANK_RESET_ALL_EN
  assign reset_all = accept && (message.data_byte1 == CC_RESET_ALL);
  assign push_data = reset_all ? {1'b1, SLOT_W'(NUM_PARAMS-1)} : {1'b0, hit_idx[SLOT_W-1:0]};
`else
  assign reset_all = 1'b0;
  assign push_data = hit_idx[SLOT_W-1:0];
`endif

  assign push = reset_all || (accept && hit);

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < NUM_PARAMS; i++) slot_q[i] <= DEFAULTS[VALUE_W*i +: VALUE_W];
    end else if (reset_all) begin
      for (int i = 0; i < NUM_PARAMS; i++) slot_q[i] <= DEFAULTS[VALUE_W*i +: VALUE_W];
    end else if (accept && hit) begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        if (hit_idx == param_index_t'(i))
          slot_q[i] <= hit_lsb ? ((slot_q[i] & UPPER_MASK) | lsb_bits) : msb_val;
      end
    end
  end

  for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_slot
    assign values[VALUE_W*g +: VALUE_W] = slot_q[g];
  end

  // Full always implies non-empty, so a ready consumer frees a slot this same edge.
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) overflow <= 1'b0;
    else if (push && full && !change_ready) overflow <= 1'b1;
  end

  change_fifo #(
    .WIDTH(IDX_W),
    .DEPTH(FIFO_DEPTH)
  ) u_change_fifo (
    .clock    (clock_50_000_000),
    .reset_l  (reset_l),
    .push     (push),
    .push_data(push_data),
    .pop      (change_ready),
    .pop_data (change_index),
    .full     (full),
    .empty    (empty)
  );

  assign change_valid = !empty;

endmodule
